// File: rtl/aib_cfg_avmm_resp.sv
// Avalon-MM configuration responder for one AIB channel: channel decode, CSR file, sticky errors.
// Define AIB_CFG_WR_LOCK_EN to add the STATUS[8] LOCK bit that blocks writes to the RW words.
module aib_cfg_avmm_resp #(
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter logic [31:0] ID_VALUE   = 32'hA1B0_0001
) (
    input  logic                         i_cfg_avmm_clk,
    input  logic                         i_cfg_avmm_rst_n,
    input  logic [5:0]                   i_channel_id,
    input  logic [16:0]                  i_cfg_avmm_addr,
    input  logic [3:0]                   i_cfg_avmm_byte_en,
    input  logic                         i_cfg_avmm_read,
    input  logic                         i_cfg_avmm_write,
    input  logic [31:0]                  i_cfg_avmm_wdata,
    output logic [31:0]                  o_cfg_avmm_rdata,
    output logic                         o_cfg_avmm_rdatavld,
    output logic                         o_cfg_avmm_waitreq,
    output logic [(NUM_REGS-2)*32-1:0]   o_csr,
    output logic                         o_cfg_err
);
    localparam int unsigned DW    = 32;
    localparam int unsigned IDX_W = 9;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned NERR  = 4;
    localparam int unsigned NBYTE = 4;

    typedef enum logic [1:0] {IDLE, WR_TURN, RD_WAIT, RD_RESP} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [DW-1:0]                  cap_q, cap_d;
    logic [NUM_REGS-1:2][DW-1:0]    csr_q, csr_d;
    logic [NERR-1:0]                err_q, err_d, err_set_c;
    logic                           lock_q;
    logic                           lock_d;
    logic [DW-1:0]                  rdata_d;
    logic                           rdatavld_d, waitreq_d, cfg_err_d;

    logic [IDX_W-1:0]               idx_c;
    logic                           chan_ok_c, idx_ok_c, accept_c, wr_ok_c;
    logic [DW-1:0]                  status_c, rd_word_c;
    logic                           unused_c;

    assign unused_c  = ^i_cfg_avmm_addr[1:0];
    assign idx_c     = i_cfg_avmm_addr[10:2];
    assign chan_ok_c = (i_cfg_avmm_addr[16:11] == i_channel_id);
    assign idx_ok_c  = ({1'b0, idx_c} < (IDX_W+1)'(NUM_REGS));
    assign accept_c  = (state_q == IDLE) && !o_cfg_avmm_waitreq &&
                       (i_cfg_avmm_read || i_cfg_avmm_write);
    assign wr_ok_c   = accept_c && i_cfg_avmm_write && chan_ok_c && idx_ok_c;
    assign status_c  = {23'd0, lock_q, 4'd0, err_q};
    assign o_csr     = csr_q;

    // Read-side decode; out-of-channel or out-of-range words read as zero.
    always_comb begin
        rd_word_c = '0;
        if (chan_ok_c && idx_ok_c) begin
            if (idx_c == IDX_W'(0)) begin
                rd_word_c = ID_VALUE;
            end else if (idx_c == IDX_W'(1)) begin
                rd_word_c = status_c;
            end else begin
                for (int unsigned i = 2; i < NUM_REGS; i++) begin
                    if (idx_c == IDX_W'(i)) rd_word_c = csr_q[i];
                end
            end
        end
    end

    // Next-state, register-file update and registered-output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cap_d     = cap_q;
        csr_d     = csr_q;
        err_set_c = '0;
        lock_d    = lock_q;
        err_d     = err_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (i_cfg_avmm_write) begin
                        state_d = WR_TURN;
                    end else if (RD_LATENCY <= 1) begin
                        state_d = RD_RESP;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_W'(RD_LATENCY - 1);
                    end
                end
            end
            WR_TURN: state_d = IDLE;
            RD_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RD_RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept_c) begin
            cap_d        = rd_word_c;
            err_set_c[0] = !chan_ok_c;
            err_set_c[1] = !idx_ok_c;
            err_set_c[2] = i_cfg_avmm_read && i_cfg_avmm_write;
        end

        if (wr_ok_c) begin
            if (idx_c == IDX_W'(1)) begin
                if (i_cfg_avmm_byte_en[0]) err_d = err_q & ~i_cfg_avmm_wdata[NERR-1:0];
`ifdef AIB_CFG_WR_LOCK_EN
                if (i_cfg_avmm_byte_en[1]) lock_d = i_cfg_avmm_wdata[8];
`endif
            end else if (idx_c >= IDX_W'(2)) begin
                if (lock_q) begin
                    err_set_c[3] = 1'b1;
                end else begin
                    for (int unsigned i = 2; i < NUM_REGS; i++) begin
                        if (idx_c == IDX_W'(i)) begin
                            for (int unsigned k = 0; k < NBYTE; k++) begin
                                if (i_cfg_avmm_byte_en[k])
                                    csr_d[i][8*k +: 8] = i_cfg_avmm_wdata[8*k +: 8];
                            end
                        end
                    end
                end
            end
        end

        // Error set wins over a same-cycle write-1-to-clear.
        err_d      = err_d | err_set_c;
        waitreq_d  = (state_d != IDLE);
        rdatavld_d = (state_d == RD_RESP);
        rdata_d    = rdatavld_d ? cap_d : '0;
        cfg_err_d  = |err_d;
    end

    always_ff @(posedge i_cfg_avmm_clk) begin
        if (!i_cfg_avmm_rst_n) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            cap_q               <= '0;
            csr_q               <= '0;
            err_q               <= '0;
            o_cfg_avmm_waitreq  <= 1'b1;
            o_cfg_avmm_rdatavld <= 1'b0;
            o_cfg_avmm_rdata    <= '0;
            o_cfg_err           <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            cap_q               <= cap_d;
            csr_q               <= csr_d;
            err_q               <= err_d;
            o_cfg_avmm_waitreq  <= waitreq_d;
            o_cfg_avmm_rdatavld <= rdatavld_d;
            o_cfg_avmm_rdata    <= rdata_d;
            o_cfg_err           <= cfg_err_d;
        end
    end

`ifdef AIB_CFG_WR_LOCK_EN
    always_ff @(posedge i_cfg_avmm_clk) begin
        if (!i_cfg_avmm_rst_n) lock_q <= 1'b0;
        else                   lock_q <= lock_d;
    end
`else
    assign lock_q = 1'b0;
`endif

endmodule
